// File: rtl/banco_registradores.sv
// 32 x DATA_W MIPS register file: two combinational read ports, one write port.
// $0 reads zero, $28/$29 come out of reset with gp/sp values.
module banco_registradores #(
    parameter int unsigned       DATA_W   = 32,
    parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(32'h0000_3FFC),
    parameter logic [DATA_W-1:0] GP_RESET = DATA_W'(32'h0000_1800),
    parameter bit                BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [4:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [4:0]        raddr1,
    input  logic [4:0]        raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0] regs [1:31];
    logic [31:1]       wen;
    logic [DATA_W-1:0] stored1;
    logic [DATA_W-1:0] stored2;
    logic              hit1;
    logic              hit2;

    always_comb begin
        wen = '0;
        for (int i = 1; i < 32; i++) begin
            wen[i] = we && (waddr == 5'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < 32; i++) begin
                if (i == 29) begin
                    regs[i] <= SP_RESET;
                end else if (i == 28) begin
                    regs[i] <= GP_RESET;
                end else begin
                    regs[i] <= '0;
                end
            end
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (wen[i]) begin
                    regs[i] <= wdata;
                end
            end
        end
    end

    always_comb begin
        stored1 = '0;
        stored2 = '0;
        if (raddr1 != 5'd0) begin
            stored1 = regs[raddr1];
        end
        if (raddr2 != 5'd0) begin
            stored2 = regs[raddr2];
        end
    end

    // Forwarding never matches address 0, so $0 stays zero on both ports.
    always_comb begin
        hit1 = BYPASS && we && (waddr != 5'd0) && (raddr1 == waddr);
        hit2 = BYPASS && we && (waddr != 5'd0) && (raddr2 == waddr);
    end

    assign rdata1 = hit1 ? wdata : stored1;
    assign rdata2 = hit2 ? wdata : stored2;

    a_write_known: assert property (@(posedge clk) disable iff (!rst_n)
        !$isunknown(we) && !(we && $isunknown(waddr)));

endmodule

// File: tb/tb_banco_registradores.sv
// Random and directed checks of banco_registradores against an array model,
// with forwarding and non-forwarding instances driven in parallel.
`timescale 1ns/100ps
module tb_banco_registradores;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [4:0]  raddr1 = '0;
    logic [4:0]  raddr2 = '0;
    logic [31:0] rd1_b;
    logic [31:0] rd2_b;
    logic [31:0] rd1_n;
    logic [31:0] rd2_n;

    logic [31:0] mdl [0:31];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    banco_registradores #(.BYPASS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1_b), .rdata2(rd2_b)
    );

    banco_registradores #(.BYPASS(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1_n), .rdata2(rd2_n)
    );

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        mdl[29] = 32'h0000_3FFC;
        mdl[28] = 32'h0000_1800;
    endtask

    function automatic logic [31:0] expv(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'h0;
        if (byp && we && rst_n && waddr == a) return wdata;
        return mdl[a];
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, o, e);
        end
    endtask

    task automatic chk4(input string tag);
        chk({tag, "/byp_p1"}, rd1_b, expv(raddr1, 1'b1));
        chk({tag, "/byp_p2"}, rd2_b, expv(raddr2, 1'b1));
        chk({tag, "/nob_p1"}, rd1_n, expv(raddr1, 1'b0));
        chk({tag, "/nob_p2"}, rd2_n, expv(raddr2, 1'b0));
    endtask

    task automatic readall(input string tag);
        @(negedge clk);
        we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i);
            raddr2 = 5'(31 - i);
            #1 chk4(tag);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d,
                      input logic [4:0] r1, input logic [4:0] r2,
                      input string tag);
        @(negedge clk);
        we = 1'b1;
        waddr = a;
        wdata = d;
        raddr1 = r1;
        raddr2 = r2;
        #1 chk4({tag, "_pre"});
        @(posedge clk);
        if (a != 5'd0) mdl[a] = d;
        #1 chk4({tag, "_post"});
    endtask

    initial begin
        logic [4:0] a;
        model_reset();
        #12;
        readall("rst_init");
        rst_n = 1'b1;

        for (int i = 0; i < 40; i++) begin
            a = 5'($urandom_range(0, 31));
            if (i % 2 == 0) wr(a, $urandom, a, 5'($urandom_range(0, 31)), "rand_hit");
            else wr(a, $urandom, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), "rand");
        end
        readall("rand_rb");

        @(negedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1 chk4("rst_mid");
        readall("rst_mid_rb");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 1; i < 32; i++) begin
            wr(5'(i), 32'hA5A5_0000 + 32'(i), 5'(i), 5'd0, "fill");
        end
        readall("fill_rb");

        wr(5'd0, 32'hDEAD_BEEF, 5'd0, 5'd0, "wzero");
        chk("wzero_direct", rd1_b, 32'h0);

        wr(5'd5, 32'h1111, 5'd5, 5'd5, "r5_a");
        @(negedge clk);
        we = 1'b1;
        waddr = 5'd5;
        wdata = 32'h2222;
        raddr1 = 5'd5;
        raddr2 = 5'd5;
        #1;
        chk("byp_pre1", rd1_b, 32'h2222);
        chk("byp_pre2", rd2_b, 32'h2222);
        chk("nob_pre1", rd1_n, 32'h1111);
        chk("nob_pre2", rd2_n, 32'h1111);
        @(posedge clk);
        mdl[5] = 32'h2222;
        #1;
        chk("nob_post1", rd1_n, 32'h2222);
        chk("nob_post2", rd2_n, 32'h2222);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            we = 1'b0;
            waddr = 5'($urandom_range(0, 31));
            wdata = $urandom;
        end
        readall("we0_rb");

        wr(5'd7, 32'h1234, 5'd7, 5'd7, "r7_pre");
        @(negedge clk);
        we = 1'b1;
        waddr = 5'd7;
        wdata = 32'h7777;
        raddr1 = 5'd7;
        raddr2 = 5'd29;
        #0.5 rst_n = 1'b0;
        model_reset();
        #3 rst_n = 1'b1;
        #0.5;
        we = 1'b0;
        #0.1;
        chk("pulse_r7", rd1_n, 32'h0);
        chk("pulse_sp", rd2_n, 32'h0000_3FFC);
        chk4("pulse");
        wr(5'd7, 32'h7777, 5'd7, 5'd28, "after_pulse");
        readall("final_rb");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
